// File: rtl/q_average_sequencer_if.sv
// Signal bundle between the averaging sequencer, the charge-measurement stage and the result consumer.
// The master side is the sequencer; the slave side is everything around it.
interface q_average_sequencer_if #(
    parameter int WIDTH = 10
);
    logic             enable;
    logic             meas_start;
    logic             meas_ready;
    logic [WIDTH-1:0] measured_q;
    logic [WIDTH-1:0] avg_q;
    logic             avg_valid;
    logic             avg_accept;
    logic             timeout_err;

    modport master (
        input  enable, meas_ready, measured_q, avg_accept,
        output meas_start, avg_q, avg_valid, timeout_err
    );

    modport slave (
        output enable, meas_ready, measured_q, avg_accept,
        input  meas_start, avg_q, avg_valid, timeout_err
    );
endinterface

// File: rtl/q_average_sequencer.sv
// Drives the charge-measurement stage through 2^N_LOG2 start/ready cycles and emits the truncated
// average on a valid/accept handshake, with a watchdog that abandons a batch whose measurement hangs.
module q_average_sequencer #(
    parameter int WIDTH         = 10,
    parameter int N_LOG2        = 2,
    parameter int REARM_CYCLES  = 2,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    q_average_sequencer_if.master bus
);
    localparam int ACC_W = WIDTH + N_LOG2;
    localparam int CNT_W = (N_LOG2 > 0) ? N_LOG2 : 1;
    localparam int ARM_W = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0]         ARM_LAST = ARM_W'(REARM_CYCLES - 1);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << N_LOG2) - 1);
    // The watchdog reaches its terminal count on the edge where it would step from this value.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST  = TIMEOUT_WIDTH'((1 << TIMEOUT_WIDTH) - 2);

    typedef enum logic [2:0] {
        IDLE, ARM, MEASURE, SETTLE, ACCUM, OUTPUT
    } state_t;

    state_t                   state, state_n;
    logic [ARM_W-1:0]         arm_cnt;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic [ACC_W-1:0]         acc, acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic                     last_sample;
    logic                     acc_clr, acc_add, avg_load, timeout_hit;
    logic                     meas_start_r, avg_valid_r, timeout_err_r;
    logic [WIDTH-1:0]         avg_q_r;

    assign acc_sum     = acc + ACC_W'(bus.measured_q);
    assign last_sample = (N_LOG2 == 0) || (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
        state_n     = state;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;
        avg_load    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                acc_clr = 1'b1;
                if (bus.enable) state_n = ARM;
            end
            ARM: begin
                if (!bus.enable) begin
                    acc_clr = 1'b1;
                    state_n = IDLE;
                end else if (arm_cnt == ARM_LAST) begin
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                // A ready on the terminal-count edge wins over the timeout.
                if (!bus.enable) begin
                    acc_clr = 1'b1;
                    state_n = IDLE;
                end else if (bus.meas_ready) begin
                    state_n = SETTLE;
                end else if (wd == WD_LAST) begin
                    timeout_hit = 1'b1;
                    acc_clr     = 1'b1;
                    state_n     = ARM;
                end
            end
            SETTLE: begin
                if (!bus.enable) begin
                    acc_clr = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (!bus.enable) begin
                    acc_clr = 1'b1;
                    state_n = IDLE;
                end else begin
                    acc_add = 1'b1;
                    if (last_sample) begin
                        avg_load = 1'b1;
                        state_n  = OUTPUT;
                    end else begin
                        state_n = ARM;
                    end
                end
            end
            OUTPUT: begin
                if (bus.avg_accept) begin
                    acc_clr = 1'b1;
                    state_n = bus.enable ? ARM : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (rst) begin
            arm_cnt       <= '0;
            wd            <= '0;
            acc           <= '0;
            cnt           <= '0;
            avg_q_r       <= '0;
            meas_start_r  <= 1'b0;
            avg_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            arm_cnt <= (state == ARM) ? arm_cnt + 1'b1 : '0;
            wd      <= (state == MEASURE && !bus.meas_ready) ? wd + 1'b1 : '0;
            if (acc_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_add) begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
            if (avg_load) avg_q_r <= WIDTH'(acc_sum >> N_LOG2);
            // Outputs are decoded from the next state so they line up with the state they describe.
            meas_start_r  <= (state_n inside {MEASURE, SETTLE, ACCUM});
            avg_valid_r   <= (state_n == OUTPUT);
            timeout_err_r <= timeout_hit;
        end
    end

    assign bus.meas_start  = meas_start_r;
    assign bus.avg_valid   = avg_valid_r;
    assign bus.avg_q       = avg_q_r;
    assign bus.timeout_err = timeout_err_r;
endmodule
